instr_fetch_unit: RTL and testbench

Upstream stage of the main decoder. Holds the program counter, fetches 32-bit instructions from instruction memory over a req/ack handshake, and presents the instruction and its opcode field [31:26] to the decoder. Uses the decoder's jump_f and branch_f, plus the ALU zero flag, to select the next PC when the current instruction retires. Replaces the combinational PC/next-PC path so the core tolerates multi-cycle instruction memory.

---
 rtl/fetch_pkg.sv | 28 ++
 rtl/instr_fetch_unit_next_pc.sv | 34 +++
 rtl/instr_fetch_unit.sv | 135 +++++++++++++
 tb/tb_instr_fetch_unit.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: types and constants shared by the instruction fetch unit and the
// main decoder.
//   - fetch_state_e : fetch FSM encoding (ST_FAULT is reachable only when
//                     FETCH_TIMEOUT_EN is defined)
//   - field geometry of the 32-bit instruction word
//   - opcode constants the decoder keys on
package fetch_pkg;

  localparam int PC_W       = 32;
  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 26;
  localparam int JUMP_IDX_W = 26;
  localparam int IMM_W      = 16;

  typedef enum logic [1:0] {
    ST_REQ   = 2'd0,
    ST_ISSUE = 2'd1,
    ST_FAULT = 2'd2
  } fetch_state_e;

  localparam logic [5:0] OPC_RTYPE = 6'h00;
  localparam logic [5:0] OPC_J     = 6'h02;
  localparam logic [5:0] OPC_BEQ   = 6'h04;
  localparam logic [5:0] OPC_ADDI  = 6'h08;
  localparam logic [5:0] OPC_LW    = 6'h23;
  localparam logic [5:0] OPC_SW    = 6'h2B;

endpackage

// File: rtl/instr_fetch_unit_next_pc.sv
// next_pc_calc: combinational next-PC selection for the retiring instruction.
//   in  pc_plus4 [32]  address after the held instruction
//   in  instr    [32]  held instruction word
//   in  jump_f, branch_f, zero_f  decoder / ALU flags
//   out next_pc  [32]  jump target > taken branch > pc_plus4
// All adds are 32-bit with the carry dropped, so targets wrap modulo 2^32.
module next_pc_calc
  import fetch_pkg::*;
(
  input  logic [PC_W-1:0] pc_plus4,
  input  logic [31:0]     instr,
  input  logic            jump_f,
  input  logic            branch_f,
  input  logic            zero_f,
  output logic [PC_W-1:0] next_pc
);

  logic [PC_W-1:0] jump_target;
  logic [PC_W-1:0] br_offset;
  logic [PC_W-1:0] br_target;

  // Jump keeps the 256 MB region of the following instruction.
  assign jump_target = {pc_plus4[PC_W-1:PC_W-4], instr[JUMP_IDX_W-1:0], 2'b00};
  // Word offset, sign-extended and scaled to bytes.
  assign br_offset   = {{(PC_W-IMM_W-2){instr[IMM_W-1]}}, instr[IMM_W-1:0], 2'b00};
  assign br_target   = pc_plus4 + br_offset;

  always_comb begin
    next_pc = pc_plus4;
    if (jump_f)                  next_pc = jump_target;
    else if (branch_f && zero_f) next_pc = br_target;
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: holds the PC, fetches one instruction at a time over a
// req/ack handshake and holds it for the decoder until the core retires it.
//   clk, rst            clock, synchronous active-high reset
//   imem_req/addr       fetch request (REQ state only), address = pc
//   imem_ack/rdata      memory response, sampled only in REQ
//   instr/opcode        held instruction and its [31:26] field
//   instr_valid         held instruction is valid (ISSUE state)
//   instr_ready         core retires the held instruction this cycle
//   jump_f/branch_f/zero_f  next-PC selection flags, sampled on retire
//   pc, pc_plus4        current PC and PC+4
//   fault               sticky fetch timeout
// Build option FETCH_TIMEOUT_EN: when defined, a REQ phase lasting
// TIMEOUT_CYCLES cycles without ack parks the unit in ST_FAULT until reset.
// When undefined, REQ waits forever and fault is tied low.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter int          TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [5:0]  opcode,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        jump_f,
  input  logic        branch_f,
  input  logic        zero_f,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        fault
);

  fetch_state_e    state, state_nxt;
  logic [PC_W-1:0] pc_nxt, next_pc;
  logic [31:0]     instr_nxt;

`ifdef FETCH_TIMEOUT_EN
  logic [15:0] to_cnt, cnt_nxt;
  logic        fault_q, fault_nxt;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES == 0);
`endif

  next_pc_calc u_next_pc (
    .pc_plus4 (pc_plus4),
    .instr    (instr),
    .jump_f   (jump_f),
    .branch_f (branch_f),
    .zero_f   (zero_f),
    .next_pc  (next_pc)
  );

  assign pc_plus4    = pc + 32'd4;
  assign imem_addr   = pc;
  assign imem_req    = (state == ST_REQ);
  assign instr_valid = (state == ST_ISSUE);
  assign opcode      = instr[OPCODE_MSB:OPCODE_LSB];
`ifdef FETCH_TIMEOUT_EN
  assign fault       = fault_q;
`else
  assign fault       = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_REQ;
      pc      <= RESET_PC;
      instr   <= '0;
`ifdef FETCH_TIMEOUT_EN
      to_cnt  <= '0;
      fault_q <= 1'b0;
`endif
    end else begin
      state   <= state_nxt;
      pc      <= pc_nxt;
      instr   <= instr_nxt;
`ifdef FETCH_TIMEOUT_EN
      to_cnt  <= cnt_nxt;
      fault_q <= fault_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    instr_nxt = instr;
`ifdef FETCH_TIMEOUT_EN
    cnt_nxt   = to_cnt;
    fault_nxt = fault_q;
`endif
    case (state)
      ST_REQ: begin
        if (imem_ack) begin
          instr_nxt = imem_rdata;
          state_nxt = ST_ISSUE;
        end
`ifdef FETCH_TIMEOUT_EN
        // An ack on the limiting cycle wins over the timeout.
        else if (to_cnt + 16'd1 == 16'(TIMEOUT_CYCLES)) begin
          state_nxt = ST_FAULT;
          fault_nxt = 1'b1;
        end else begin
          cnt_nxt = to_cnt + 16'd1;
        end
`endif
      end
      ST_ISSUE: begin
        if (instr_ready) begin
          pc_nxt    = next_pc;
          state_nxt = ST_REQ;
`ifdef FETCH_TIMEOUT_EN
          cnt_nxt   = '0;
`endif
        end
      end
      default: begin
`ifdef FETCH_TIMEOUT_EN
        // ST_FAULT: hold everything until reset.
        state_nxt = state;
`else
        state_nxt = ST_REQ;
`endif
      end
    endcase
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req, imem_ack, instr_valid, instr_ready;
  logic        jump_f, branch_f, zero_f, fault;
  logic [31:0] imem_addr, imem_rdata, instr, pc, pc_plus4;
  logic [5:0]  opcode;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  instr_fetch_unit #(.RESET_PC(RST_PC), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr(instr), .opcode(opcode),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .jump_f(jump_f),
    .branch_f(branch_f), .zero_f(zero_f), .pc(pc), .pc_plus4(pc_plus4), .fault(fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        cur;
  logic        prev_valid = 1'b0;
  logic [31:0] model_pc;
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    chk(name, {31'd0, act}, {31'd0, exp});
  endtask

  // Reference next-PC, written from the architectural rules.
  function automatic logic [31:0] model_next(input logic [31:0] p, input logic [31:0] ins,
                                             input logic j, input logic b, input logic z);
    logic [31:0] p4;
    int          off;
    p4 = p + 32'd4;
    if (j) return (p4 & 32'hF000_0000) + (ins & 32'h03FF_FFFF) * 32'd4;
    off = int'($signed(ins[15:0])) * 4;
    if (b && z) return p4 + 32'(off);
    return p4;
  endfunction

  // Monitor: each new instr_valid pops one expected fetch; while valid, the
  // held instruction and pc must stay equal to it and no request may be up.
  always @(negedge clk) begin
    if (rst) begin
      prev_valid = 1'b0;
    end else begin
      if (instr_valid) begin
        if (!prev_valid) begin
          if (sb_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_issue: got instr %h expected none", instr);
            cur = '{pc, instr};
          end else begin
            cur = sb_q.pop_front();
          end
        end
        chk("mon_instr", instr, cur.instr);
        chk("mon_pc", pc, cur.pc);
        chk("mon_opcode", {26'd0, opcode}, {26'd0, cur.instr[31:26]});
        chk("mon_pc_plus4", pc_plus4, cur.pc + 32'd4);
        chk1("mon_no_req", imem_req, 1'b0);
      end
      prev_valid = instr_valid;
    end
  end

  task automatic rand_flags();
    jump_f   = 1'($urandom);
    branch_f = 1'($urandom);
    zero_f   = 1'($urandom);
  endtask

  task automatic req_cycle(input string tag);
    rand_flags();
    instr_ready = 1'($urandom);
    imem_ack    = 1'b0;
    chk1({tag, "_req"}, imem_req, 1'b1);
    chk1({tag, "_novalid"}, instr_valid, 1'b0);
    chk({tag, "_addr"}, imem_addr, model_pc);
    chk1({tag, "_fault"}, fault, 1'b0);
  endtask

  // One fetch: lat REQ cycles without ack, ack, hold cycles with ready low,
  // then retire with the given flags.
  task automatic fetch(input logic [31:0] rdata, input int lat, input int hold,
                       input logic j, input logic b, input logic z);
    for (int i = 0; i < lat; i++) begin
      @(negedge clk);
      req_cycle("wait");
    end
    @(negedge clk);
    req_cycle("ack");
    imem_ack   = 1'b1;
    imem_rdata = rdata;
    sb_q.push_back('{model_pc, rdata});
    @(negedge clk);
    chk1("valid_lat", instr_valid, 1'b1);
    for (int i = 0; i < hold; i++) begin
      imem_ack    = 1'($urandom);
      imem_rdata  = $urandom;
      instr_ready = 1'b0;
      rand_flags();
      @(negedge clk);
    end
    imem_ack    = 1'($urandom);
    imem_rdata  = $urandom;
    instr_ready = 1'b1;
    jump_f      = j;
    branch_f    = b;
    zero_f      = z;
    model_pc    = model_next(model_pc, rdata, j, b, z);
  endtask

  // Reset in REQ with an ack on the same edge; the ack must be lost.
  task automatic reset_with_ack();
    @(negedge clk);
    rst         = 1'b1;
    imem_ack    = 1'b1;
    imem_rdata  = 32'hDEAD_BEEF;
    instr_ready = 1'b0;
    @(negedge clk);
    rst      = 1'b0;
    imem_ack = 1'b0;
    model_pc = RST_PC;
    sb_q.delete();
    chk1("rst_valid", instr_valid, 1'b0);
    chk1("rst_req", imem_req, 1'b1);
    chk("rst_addr", imem_addr, RST_PC);
    chk("rst_instr", instr, 32'd0);
    chk1("rst_fault", fault, 1'b0);
  endtask

  initial begin
    rst = 1'b1; imem_ack = 1'b0; imem_rdata = '0; instr_ready = 1'b0;
    jump_f = 1'b0; branch_f = 1'b0; zero_f = 1'b0;
    model_pc = RST_PC;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk1("reset_req", imem_req, 1'b1);
    chk("reset_addr", imem_addr, RST_PC);
    chk1("reset_valid", instr_valid, 1'b0);
    chk("reset_opcode", {26'd0, opcode}, 32'd0);
    chk("reset_pc_plus4", pc_plus4, 32'd4);

    // Directed walk through the main next-PC cases.
    fetch(32'h2008_0005, 2, 0, 1'b0, 1'b0, 1'b0);  // addi at 0 -> 4
    chk("addi_opcode_bits", 32'h2008_0005 >> 26, 32'h0000_0008);
    fetch(32'h0810_0002, 1, 0, 1'b1, 1'b0, 1'b0);  // jump to 0x0040_0008
    fetch(32'h0800_0010, 0, 0, 1'b1, 1'b0, 1'b0);  // jump to 0x40
    fetch(32'h0800_0040, 0, 0, 1'b1, 1'b0, 1'b0);  // jump to 0x100
    fetch(32'h1000_FFFF, 0, 0, 1'b0, 1'b1, 1'b1);  // beq taken: stays 0x100
    fetch(32'h1000_FFFF, 1, 0, 1'b0, 1'b1, 1'b0);  // beq not taken: 0x104
    fetch(32'h0800_0000, 0, 0, 1'b1, 1'b0, 1'b0);  // jump to 0
    fetch(32'h1000_FFFE, 0, 0, 1'b0, 1'b1, 1'b1);  // branch wraps to FFFF_FFFC
    fetch(32'h0000_0020, 0, 5, 1'b0, 1'b0, 1'b0);  // held 5 cycles, wraps to 0
    fetch(32'h0800_0100, 0, 0, 1'b1, 1'b1, 1'b1);  // jump beats branch -> 0x400
    @(negedge clk);
    req_cycle("after_jb");
    chk("jump_wins", imem_addr, 32'h0000_0400);

    reset_with_ack();
    fetch(32'h2000_0001, 3, 0, 1'b0, 1'b0, 1'b0);  // ack on 4th REQ cycle

    // Randomized fetches.
    for (int n = 0; n < 60; n++) begin
`ifdef FETCH_TIMEOUT_EN
      fetch($urandom, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
            ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0), 1'($urandom));
`else
      fetch($urandom, int'($urandom_range(0, 6)), int'($urandom_range(0, 3)),
            ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0), 1'($urandom));
`endif
    end

`ifdef FETCH_TIMEOUT_EN
    // Four REQ cycles with no ack -> fault, sticky until reset.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      req_cycle("to_wait");
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      imem_ack = 1'($urandom);
      chk1("to_fault", fault, 1'b1);
      chk1("to_req", imem_req, 1'b0);
      chk1("to_valid", instr_valid, 1'b0);
      chk("to_pc", pc, model_pc);
    end
    reset_with_ack();
    fetch(32'h0000_0000, 3, 0, 1'b0, 1'b0, 1'b0);
`endif

    @(negedge clk);
    req_cycle("final");
    chk("sb_empty", sb_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
